// File: rtl/rsnn_pkg.sv
// Shared RSNN definitions: readback FSM encoding, stream sync header and a
// width helper for sizing counters.
package rsnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int                 HDR_LEN = 4;
    localparam logic [HDR_LEN-1:0] HDR     = 4'b1010;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_readback_serializer_if.sv
// Bit-serial readback stream with valid/ready flow control.
interface reg_readback_serializer_if;

    logic sout;
    logic sout_valid;
    logic sout_ready;

    modport master (output sout, output sout_valid, input sout_ready);
    modport slave  (input sout, input sout_valid, output sout_ready);

endinterface

// File: rtl/reg_readback_serializer_bit_mux.sv
// Selects snapshot bit [reg_idx][WIDTH-1-bit_cnt]: register 0 first, MSB first.
module readback_bit_mux #(
    parameter int WIDTH    = 3,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int BIT_W    = 2
) (
    input  logic [NUM_REGS*WIDTH-1:0] snap_i,
    input  logic [IDX_W-1:0]          reg_idx_i,
    input  logic [BIT_W-1:0]          bit_cnt_i,
    output logic                      bit_o
);

    // Out-of-range index codes (non power-of-two sizes) read as 0.
    always_comb begin
        bit_o = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (reg_idx_i == IDX_W'(r) && bit_cnt_i == BIT_W'(b)) begin
                    bit_o = snap_i[r*WIDTH + WIDTH - 1 - b];
                end
            end
        end
    end

endmodule

// File: rtl/reg_readback_serializer.sv
// Snapshots the parameter register bank on start and streams it out as
// sync header, data bits (reg 0 first, MSB first) and an even-parity bit.
module reg_readback_serializer
    import rsnn_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
    reg_readback_serializer_if.master sout_if,
    output logic                      busy,
    output logic                      done
);

    localparam int               IDX_W    = clog2_min1(NUM_REGS);
    localparam int               BIT_W    = clog2_min1(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [1:0]       HDR_LAST = 2'(HDR_LEN - 1);

    state_e                      state_q, state_d;
    logic [NUM_REGS*WIDTH-1:0]   snap_q, snap_d;
    logic [1:0]                  hdr_cnt_q, hdr_cnt_d;
    logic [IDX_W-1:0]            reg_idx_q, reg_idx_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic                        data_bit;
    logic                        xfer;

    readback_bit_mux #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .BIT_W    (BIT_W)
    ) u_bit_mux (
        .snap_i    (snap_q),
        .reg_idx_i (reg_idx_q),
        .bit_cnt_i (bit_cnt_q),
        .bit_o     (data_bit)
    );

    assign xfer = sout_if.sout_valid & sout_if.sout_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            // NOTE: the snapshot is cleared on reset too, so a frame abandoned
            // by reset leaves no stale register contents behind.
            snap_q    <= '0;
            hdr_cnt_q <= '0;
            reg_idx_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            hdr_cnt_q <= hdr_cnt_d;
            reg_idx_q <= reg_idx_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Counters only move on a transfer, so a stalled bit is held unchanged.
    always_comb begin
        // NOTE: every next-state signal defaults to hold before the case,
        // which keeps this block free of inferred latches.
        state_d   = state_q;
        snap_d    = snap_q;
        hdr_cnt_d = hdr_cnt_q;
        reg_idx_d = reg_idx_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d    = reg_bus;
                    hdr_cnt_d = '0;
                    reg_idx_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (reg_idx_q == IDX_LAST) begin
                            reg_idx_d = '0;
                            state_d   = ST_PARITY;
                        end else begin
                            reg_idx_d = reg_idx_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (xfer) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them at once.
    always_comb begin
        sout_if.sout       = 1'b0;
        sout_if.sout_valid = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        unique case (state_q)
            ST_HEADER: begin
                sout_if.sout       = HDR[HDR_LAST - hdr_cnt_q];
                sout_if.sout_valid = 1'b1;
                busy               = 1'b1;
            end
            ST_DATA: begin
                sout_if.sout       = data_bit;
                sout_if.sout_valid = 1'b1;
                busy               = 1'b1;
            end
            ST_PARITY: begin
                sout_if.sout       = ^snap_q;
                sout_if.sout_valid = 1'b1;
                busy               = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_readback_serializer.sv
// Scoreboard bench: two serializer configurations, expected frames built from
// the stream framing rules and checked by per-instance monitors.
module tb_reg_readback_serializer;

    localparam int WA = 3, NA = 2, WB = 4, NB = 3;
    localparam int FLEN_A = 4 + NA*WA + 1;
    localparam int FLEN_B = 4 + NB*WB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_a, reset_b, start_a, start_b;
    logic [NA*WA-1:0] bus_a;
    logic [NB*WB-1:0] bus_b;
    logic             busy_a, done_a, busy_b, done_b;

    reg_readback_serializer_if if_a ();
    reg_readback_serializer_if if_b ();

    reg_readback_serializer #(.WIDTH(WA), .NUM_REGS(NA)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .reg_bus(bus_a),
        .sout_if(if_a), .busy(busy_a), .done(done_a));

    reg_readback_serializer #(.WIDTH(WB), .NUM_REGS(NB)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .reg_bus(bus_b),
        .sout_if(if_b), .busy(busy_b), .done(done_b));

    int   n_checks = 0, n_fail = 0;
    logic exp_a[$];
    logic exp_b[$];
    int   xfers[2], vcyc[2], last_v[2], done_cnt[2], rdy_mode[2], pat_idx[2];
    logic pv[2], pr[2], ps[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_bit(input int id, input logic b);
        if (id == 0) exp_a.push_back(b);
        else         exp_b.push_back(b);
    endtask

    // Reference frame: 1010 header, reg 0..n-1 MSB first, then even parity.
    task automatic push_frame(input int id, input logic [63:0] bus, input int w, input int n);
        logic [3:0] sync;
        int         ones;
        sync = 4'b1010;
        ones = 0;
        for (int i = 3; i >= 0; i--) push_bit(id, sync[i]);
        for (int r = 0; r < n; r++) begin
            for (int k = w - 1; k >= 0; k--) begin
                push_bit(id, bus[r*w + k]);
                if (bus[r*w + k]) ones++;
            end
        end
        push_bit(id, (ones % 2) == 1);
    endtask

    task automatic mon(input int id, input logic rst, input logic v, input logic s,
                       input logic r, input logic d, input int flen);
        logic e;
        if (rst) begin
            xfers[id] = 0; vcyc[id] = 0; pv[id] = 1'b0; pr[id] = 1'b0;
            return;
        end
        if (pv[id] && !pr[id]) begin
            check("hold_valid", v, 1'b1);
            check("hold_sout", s, ps[id]);
        end
        if (!v) check("idle_sout_zero", s, 1'b0);
        if (v) vcyc[id]++;
        if (v && r) begin
            if ((id == 0 && exp_a.size() == 0) || (id == 1 && exp_b.size() == 0)) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_bit dut%0d at %0t: got %0b, expected no transfer", id, $time, s);
            end else begin
                e = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check("stream_bit", s, e);
            end
            xfers[id]++;
        end
        if (d) begin
            done_cnt[id]++;
            check("frame_transfers", xfers[id], flen);
            check("done_valid_low", v, 1'b0);
            last_v[id] = vcyc[id];
            xfers[id] = 0;
            vcyc[id] = 0;
        end
        pv[id] = v; pr[id] = r; ps[id] = s;
    endtask

    always @(negedge clk) mon(0, reset_a, if_a.sout_valid, if_a.sout, if_a.sout_ready, done_a, FLEN_A);
    always @(negedge clk) mon(1, reset_b, if_b.sout_valid, if_b.sout, if_b.sout_ready, done_b, FLEN_B);

    function automatic logic rdy_val(input int mode, input int idx);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            1:       return pat[3 - (idx % 4)];
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        if_a.sout_ready = 1'b1;
        if_b.sout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if_a.sout_ready = rdy_val(rdy_mode[0], pat_idx[0]);
            if_b.sout_ready = rdy_val(rdy_mode[1], pat_idx[1]);
            pat_idx[0]++; pat_idx[1]++;
        end
    end

    // Raises start for one edge from idle; the model frame uses the bus as captured.
    task automatic start_frame(input int id, input bit change_after);
        @(posedge clk); #1;
        if (id == 0) begin
            start_a = 1'b1;
            check("pre_start_idle", if_a.sout_valid, 1'b0);
            push_frame(0, 64'(bus_a), WA, NA);
        end else begin
            start_b = 1'b1;
            check("pre_start_idle", if_b.sout_valid, 1'b0);
            push_frame(1, 64'(bus_b), WB, NB);
        end
        @(posedge clk); #1;
        if (id == 0) begin
            start_a = 1'b0;
            check("first_bit_latency", if_a.sout_valid, 1'b1);
            if (change_after) bus_a = '1;
        end else begin
            start_b = 1'b0;
            check("first_bit_latency", if_b.sout_valid, 1'b1);
            if (change_after) bus_b = '1;
        end
    endtask

    task automatic wait_done(input int id, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((id == 0 && done_a) || (id == 1 && done_b)) return;
        end
        n_checks++; n_fail++;
        $display("FAIL done_timeout dut%0d at %0t: got no done, expected done within %0d cycles", id, $time, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got no end of test, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, n;
        for (int i = 0; i < 2; i++) begin
            xfers[i] = 0; vcyc[i] = 0; last_v[i] = 0; done_cnt[i] = 0;
            rdy_mode[i] = 0; pat_idx[i] = 0; pv[i] = 1'b0; pr[i] = 1'b0; ps[i] = 1'b0;
        end
        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        bus_a = '0; bus_b = '0;
        #1;
        check("rst_valid_a", if_a.sout_valid, 1'b0);
        check("rst_sout_a", if_a.sout, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_valid_b", if_b.sout_valid, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        repeat (3) @(posedge clk);
        #1; reset_a = 1'b0; reset_b = 1'b0;

        // Basic frame, ready always high.
        bus_a = {3'b110, 3'b011};
        start_frame(0, 1'b0);
        wait_done(0, 100);
        @(posedge clk); #1;
        check("t1_valid_cycles", last_v[0], FLEN_A);
        check("t1_idle_after_done", busy_a, 1'b0);
        check("t1_queue_empty", exp_a.size(), 0);

        // Same frame under a stalling ready pattern.
        rdy_mode[0] = 1;
        start_frame(0, 1'b0);
        wait_done(0, 200);
        @(posedge clk); #1;
        check("t2_queue_empty", exp_a.size(), 0);
        rdy_mode[0] = 0;

        // Odd data parity and bus change after capture.
        bus_a = {3'b000, 3'b001};
        start_frame(0, 1'b1);
        wait_done(0, 100);
        @(posedge clk); #1;
        check("t3_queue_empty", exp_a.size(), 0);

        // Start during DATA is ignored.
        bus_a = 6'($urandom);
        start_frame(0, 1'b0);
        d0 = done_cnt[0];
        repeat (6) @(posedge clk);
        #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        wait_done(0, 100);
        repeat (4) @(posedge clk);
        #1;
        check("t4_single_done", done_cnt[0], d0 + 1);
        check("t4_no_extra_frame", if_a.sout_valid, 1'b0);

        // Start held high: back-to-back frames two cycles after done.
        bus_a = 6'($urandom);
        @(posedge clk); #1; start_a = 1'b1;
        push_frame(0, 64'(bus_a), WA, NA);
        wait_done(0, 100);
        push_frame(0, 64'(bus_a), WA, NA);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); n++;
            if (if_a.sout_valid) break;
        end
        check("t4_gap_after_done", n, 2);
        start_a = 1'b0;
        wait_done(0, 100);
        @(posedge clk); #1;
        check("t4_queue_empty", exp_a.size(), 0);

        // Reset mid-frame at reg_idx=1, bit_cnt=1.
        bus_a = 6'($urandom);
        start_frame(0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("t5_in_data", if_a.sout_valid, 1'b1);
        d0 = done_cnt[0];
        reset_a = 1'b1;
        exp_a.delete();
        #1;
        check("t5_rst_valid", if_a.sout_valid, 1'b0);
        check("t5_rst_sout", if_a.sout, 1'b0);
        check("t5_rst_busy", busy_a, 1'b0);
        check("t5_rst_done", done_a, 1'b0);
        @(posedge clk); #1; reset_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt[0], d0);
        bus_a = 6'($urandom);
        start_frame(0, 1'b0);
        wait_done(0, 100);
        @(posedge clk); #1;
        check("t5_valid_cycles", last_v[0], FLEN_A);
        check("t5_queue_empty", exp_a.size(), 0);

        // Larger bank, random data and random ready.
        rdy_mode[1] = 2;
        for (int f = 0; f < 20; f++) begin
            bus_b = 12'($urandom);
            start_frame(1, (f % 3) == 0);
            wait_done(1, 400);
            @(posedge clk); #1;
        end
        check("t6_queue_empty", exp_b.size(), 0);
        rdy_mode[1] = 0;
        bus_b = 12'($urandom);
        start_frame(1, 1'b0);
        wait_done(1, 100);
        @(posedge clk); #1;
        check("t6_valid_cycles", last_v[1], FLEN_B);
        check("t6_final_empty", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
